riscv_fetch: RTL and testbench

Instruction-fetch stage of the RV32I core, placed directly upstream of decode. It owns the program counter and issues word fetches to instruction memory over a request/grant/response interface, with at most one fetch outstanding. Each returned instruction is presented to decode through a valid/ready handshake. Control-flow redirects from execute flush the stage and restart fetching at the new PC.

---
 rtl/riscv_fetch.sv | 178 +++++++++++++++++
 tb/tb_riscv_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch.sv
// RV32I instruction-fetch stage: owns the PC, keeps one imem fetch in flight and hands words to decode.
// Optional RISCV_FETCH_MISALIGN_TRAP_EN: misaligned redirect targets become a flagged NOP instead of a fetch.
module riscv_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        o_fetch_imem_req,
  output logic [31:0] o_fetch_imem_addr,
  input  logic        i_fetch_imem_gnt,
  input  logic        i_fetch_imem_rvalid,
  input  logic [31:0] i_fetch_imem_rdata,
  output logic        o_fetch_valid,
  output logic [31:0] o_fetch_pc,
  output logic [31:0] o_fetch_instr,
  input  logic        i_fetch_ready,
  input  logic        i_fetch_redirect,
  input  logic [31:0] i_fetch_redirect_pc,
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  output logic        o_fetch_misalign,
`endif
  output logic [1:0]  o_fetch_state
);

  // Handshakes: an imem request is taken on req && gnt; a decode transfer on valid && ready.
  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] redir_target;
  logic        redir_misal;
  logic        pc_misal;
  logic        gnt_ok;

`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  assign redir_target = i_fetch_redirect_pc;
  assign redir_misal  = (i_fetch_redirect_pc[1:0] != 2'b00);
  assign pc_misal     = (pc_q[1:0] != 2'b00);
`else
  assign redir_target = i_fetch_redirect_pc & 32'hFFFF_FFFC;
  assign redir_misal  = 1'b0;
  assign pc_misal     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_REQ;
      pc_q     <= PC_RESET;
      req_pc_q <= 32'h0;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      out_pc_q <= 32'h0;
      instr_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      out_pc_q <= out_pc_d;
      instr_q  <= instr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    valid_d  = valid_q;
    out_pc_d = out_pc_q;
    instr_d  = instr_q;
    unique case (state_q)
      S_REQ: begin
        if (i_fetch_redirect) begin
          pc_d = redir_target;
          if (gnt_ok) begin
            // The granted fetch is already in flight; its response must be swallowed.
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end else if (redir_misal) begin
            state_d  = S_HOLD;
            valid_d  = 1'b1;
            out_pc_d = redir_target;
            instr_d  = NOP;
          end
        end else if (pc_misal) begin
          // Misaligned target that had to wait for a dropped response first.
          state_d  = S_HOLD;
          valid_d  = 1'b1;
          out_pc_d = pc_q;
          instr_d  = NOP;
        end else if (gnt_ok) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_fetch_redirect) begin
          pc_d = redir_target;
          if (i_fetch_imem_rvalid) begin
            drop_d = 1'b0;
            if (redir_misal) begin
              state_d  = S_HOLD;
              valid_d  = 1'b1;
              out_pc_d = redir_target;
              instr_d  = NOP;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            drop_d = 1'b1;
          end
        end else if (i_fetch_imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q) begin
            state_d = S_REQ;
          end else begin
            state_d  = S_HOLD;
            valid_d  = 1'b1;
            out_pc_d = req_pc_q;
            instr_d  = i_fetch_imem_rdata;
          end
        end
      end
      S_HOLD: begin
        if (i_fetch_redirect) begin
          pc_d = redir_target;
          if (redir_misal) begin
            valid_d  = 1'b1;
            out_pc_d = redir_target;
            instr_d  = NOP;
          end else begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end else if (i_fetch_ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    o_fetch_imem_req  = i_rstn && (state_q == S_REQ) && !pc_misal;
    o_fetch_imem_addr = {pc_q[31:2], 2'b00};
    gnt_ok            = i_fetch_imem_gnt && o_fetch_imem_req;
    o_fetch_valid     = valid_q;
    o_fetch_pc        = out_pc_q;
    o_fetch_instr     = instr_q;
    o_fetch_state     = state_q;
  end

`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  logic misal_q;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      misal_q <= 1'b0;
    end else if (state_d == S_HOLD &&
                 ((i_fetch_redirect && redir_misal) || (state_q == S_REQ && pc_misal))) begin
      misal_q <= 1'b1;
    end else if (state_d != S_HOLD || state_q != S_HOLD) begin
      misal_q <= 1'b0;
    end
  end
  assign o_fetch_misalign = misal_q;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: sequencing, decode stall, redirects, PC wrap and async reset.
module tb_riscv_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        valid, w_valid;
  logic [31:0] fpc, w_pc;
  logic [31:0] instr, w_instr;
  logic        ready, redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  state, w_state;
  logic [31:0] last_addr;
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  logic        misalign, w_misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_fetch u_dut (
    .i_clk(clk), .i_rstn(rstn),
    .o_fetch_imem_req(imem_req), .o_fetch_imem_addr(imem_addr),
    .i_fetch_imem_gnt(gnt), .i_fetch_imem_rvalid(rvalid), .i_fetch_imem_rdata(rdata),
    .o_fetch_valid(valid), .o_fetch_pc(fpc), .o_fetch_instr(instr),
    .i_fetch_ready(ready), .i_fetch_redirect(redirect), .i_fetch_redirect_pc(redirect_pc),
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    .o_fetch_misalign(misalign),
`endif
    .o_fetch_state(state)
  );

  riscv_fetch #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .i_clk(clk), .i_rstn(rstn),
    .o_fetch_imem_req(w_req), .o_fetch_imem_addr(w_addr),
    .i_fetch_imem_gnt(1'b1), .i_fetch_imem_rvalid(1'b1), .i_fetch_imem_rdata(32'h0000_0013),
    .o_fetch_valid(w_valid), .o_fetch_pc(w_pc), .o_fetch_instr(w_instr),
    .i_fetch_ready(1'b1), .i_fetch_redirect(1'b0), .i_fetch_redirect_pc(32'h0),
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    .o_fetch_misalign(w_misalign),
`endif
    .o_fetch_state(w_state)
  );

  // Memory model: the response word encodes the address that was granted.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) last_addr <= 32'h0;
    else if (imem_req && gnt) last_addr <= imem_addr;
  end
  assign rdata = {16'hC0DE, last_addr[15:0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; gnt = 1'b0; rvalid = 1'b0; ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_pc", fpc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_state", {30'h0, state}, 32'h0);

    // Back-to-back fetches with gnt/rvalid/ready high.
    rstn = 1'b1; gnt = 1'b1; rvalid = 1'b1;
    #1;
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    step();
    check("wait0_valid", {31'h0, valid}, 32'h0);
    check("wait0_req", {31'h0, imem_req}, 32'h0);
    step();
    check("f0_valid", {31'h0, valid}, 32'h1);
    check("f0_pc", fpc, 32'h0);
    check("f0_instr", instr, 32'hC0DE_0000);
    check("wrap_f0_pc", w_pc, 32'hFFFF_FFFC);
    step();
    check("f0_consumed", {31'h0, valid}, 32'h0);
    check("f1_addr", imem_addr, 32'h4);
    check("wrap_second_addr", w_addr, 32'h0);
    check("wrap_second_req", {31'h0, w_req}, 32'h1);
    step(); step();
    check("f1_valid", {31'h0, valid}, 32'h1);
    check("f1_pc", fpc, 32'h4);
    check("f1_instr", instr, 32'hC0DE_0004);

    // Decode stalls for 5 cycles.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'h0, valid}, 32'h1);
      check("stall_pc", fpc, 32'h4);
      check("stall_instr", instr, 32'hC0DE_0004);
      check("stall_noreq", {31'h0, imem_req}, 32'h0);
    end
    ready = 1'b1;
    step();
    check("resume_valid", {31'h0, valid}, 32'h0);
    check("resume_req", {31'h0, imem_req}, 32'h1);
    check("resume_addr", imem_addr, 32'h8);

    // Redirect coinciding with the grant for 0x8.
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("rg_wait_req", {31'h0, imem_req}, 32'h0);
    check("rg_wait_valid", {31'h0, valid}, 32'h0);
    step();
    check("rg_drop_valid", {31'h0, valid}, 32'h0);
    check("rg_new_req", {31'h0, imem_req}, 32'h1);
    check("rg_new_addr", imem_addr, 32'h100);
    step(); step();
    check("rg_f_valid", {31'h0, valid}, 32'h1);
    check("rg_f_pc", fpc, 32'h100);
    check("rg_f_instr", instr, 32'hC0DE_0100);

    // Redirect while holding with ready low.
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0; ready = 1'b1;
    check("rh_valid", {31'h0, valid}, 32'h0);
    check("rh_req", {31'h0, imem_req}, 32'h1);
    check("rh_addr", imem_addr, 32'h200);
    step(); step();
    check("rh_f_valid", {31'h0, valid}, 32'h1);
    check("rh_f_pc", fpc, 32'h200);
    check("rh_f_instr", instr, 32'hC0DE_0200);

    // Misaligned redirect target 0x102 from HOLD (ready also high).
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    check("mis_valid", {31'h0, valid}, 32'h1);
    check("mis_flag", {31'h0, misalign}, 32'h1);
    check("mis_pc", fpc, 32'h102);
    check("mis_instr", instr, 32'h0000_0013);
    check("mis_noreq", {31'h0, imem_req}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("mis_clear", {31'h0, misalign}, 32'h0);
`endif
    check("mis_fetch_valid", {31'h0, valid}, 32'h0);
    check("mis_fetch_req", {31'h0, imem_req}, 32'h1);
    check("mis_fetch_addr", imem_addr, 32'h100);
    step(); step();
    check("mis_f_valid", {31'h0, valid}, 32'h1);
    check("mis_f_pc", fpc, 32'h100);
    check("mis_f_instr", instr, 32'hC0DE_0100);

    // Asynchronous reset in the middle of a cycle while holding.
    ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("ar_valid", {31'h0, valid}, 32'h0);
    check("ar_pc", fpc, 32'h0);
    check("ar_instr", instr, 32'h0);
    check("ar_req", {31'h0, imem_req}, 32'h0);
    check("ar_addr", imem_addr, 32'h0);
    check("ar_state", {30'h0, state}, 32'h0);
    step();
    rstn = 1'b1; ready = 1'b1;
    #1;
    check("ar_rel_req", {31'h0, imem_req}, 32'h1);
    step(); step();
    check("ar_rel_pc", fpc, 32'h0);
    check("ar_rel_valid", {31'h0, valid}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
